turfio_wb_bank_bridge: RTL and testbench



---
 rtl/turfio_wb_bridge_pkg.sv | 29 ++
 rtl/turfio_wb_timeout.sv | 42 ++++
 rtl/turfio_wb_bank_bridge.sv | 189 ++++++++++++++++++
 tb/tb_turfio_wb_bank_bridge.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turfio_wb_bridge_pkg.sv
// rtl/turfio_wb_bridge_pkg.sv - shared FSM state type and width helpers for the TURFIO Wishbone bank bridge
// Contents: wb_state_e (bridge FSM states), sel_width/low_width/upper_width
// (bank-address split), cnt_width (counter width able to hold a value).
package turfio_wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BUS        = 2'd1,
      RETRY_WAIT = 2'd2,
      DONE       = 2'd3
   } wb_state_e;

   function automatic int sel_width(input int nbank);
      return $clog2(nbank);
   endfunction

   function automatic int low_width(input int cmd_aw, input int nbank);
      return cmd_aw - $clog2(nbank);
   endfunction

   function automatic int upper_width(input int wb_aw, input int cmd_aw, input int nbank);
      return wb_aw - 2 - low_width(cmd_aw, nbank);
   endfunction

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/turfio_wb_timeout.sv
// rtl/turfio_wb_timeout.sv - bus-phase cycle counter that flags a stalled Wishbone cycle
// Ports: clk, rst (async, active-high); clear zeroes the count; enable counts
// one per cycle; expired is high during the TIMEOUT_CYCLES-th enabled cycle.
module turfio_wb_timeout
   import turfio_wb_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW   = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   // count_q holds the number of enabled cycles already elapsed, so the
   // final allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
   assign expired = enable && (count_q >= LAST);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/turfio_wb_bank_bridge.sv
// rtl/turfio_wb_bank_bridge.sv - command-port to Wishbone host bridge with banked upper address, retry and error counting
// Ports: wb_clk_i/wb_rst_i (async, active-high); cmd_* request/response port;
// bank_upper_i upper-address values for banks 1..NBANK-1; wb_* Wishbone host;
// err_count_o saturating error-completion count.
// Build option: define TURFIO_WB_TIMEOUT_EN to abort BUS after TIMEOUT_CYCLES.
module turfio_wb_bank_bridge
   import turfio_wb_bridge_pkg::*;
#(
   parameter int CMD_AW         = 20,
   parameter int WB_AW          = 25,
   parameter int NBANK          = 2,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    cmd_en_i,
   input  logic                    cmd_wr_i,
   input  logic [CMD_AW-1:0]       cmd_adr_i,
   input  logic [31:0]             cmd_dat_i,
   input  logic [3:0]              cmd_wstrb_i,
   output logic [31:0]             cmd_dat_o,
   output logic                    cmd_ack_o,
   output logic                    cmd_err_o,
   output logic                    cmd_busy_o,
   input  logic [(NBANK-1)*upper_width(WB_AW, CMD_AW, NBANK)-1:0] bank_upper_i,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [WB_AW-1:0]        wb_adr_o,
   output logic [31:0]             wb_dat_o,
   output logic [3:0]              wb_sel_o,
   input  logic [31:0]             wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i,
   output logic [15:0]             err_count_o
);

   localparam int            SEL_W       = sel_width(NBANK);
   localparam int            LOW_W       = low_width(CMD_AW, NBANK);
   localparam int            UPPER_W     = upper_width(WB_AW, CMD_AW, NBANK);
   localparam int            RW          = cnt_width(MAX_RETRY);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   wb_state_e        state_q, state_d;
   logic             wr_q, wr_d;
   logic [WB_AW-1:0] adr_q, adr_d;
   logic [31:0]      wdat_q, wdat_d;
   logic [3:0]       sel_q, sel_d;
   logic [31:0]      rdat_q, rdat_d;
   logic             err_q, err_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [15:0]      err_cnt_q, err_cnt_d;

   logic [SEL_W-1:0]   bank;
   logic [UPPER_W-1:0] upper;
   logic               timeout;

   // Bank 0 always maps to upper address zero; other banks pick their slice.
   always_comb begin
      bank  = cmd_adr_i[CMD_AW-1:LOW_W];
      upper = '0;
      for (int b = 1; b < NBANK; b++) begin
         if (bank == SEL_W'(b)) begin
            upper = bank_upper_i[(b-1)*UPPER_W +: UPPER_W];
         end
      end
   end

`ifdef TURFIO_WB_TIMEOUT_EN
   // Leaving BUS (including into RETRY_WAIT) clears the count, so every
   // attempt gets a fresh window.
   turfio_wb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clear   (state_q != BUS),
      .enable  (state_q == BUS),
      .expired (timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         adr_q     <= '0;
         wdat_q    <= '0;
         sel_q     <= '0;
         rdat_q    <= '0;
         err_q     <= 1'b0;
         retry_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         sel_q     <= sel_d;
         rdat_q    <= rdat_d;
         err_q     <= err_d;
         retry_q   <= retry_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      sel_d     = sel_q;
      rdat_d    = rdat_q;
      err_d     = err_q;
      retry_d   = retry_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_en_i) begin
               state_d = BUS;
               wr_d    = cmd_wr_i;
               adr_d   = {upper, cmd_adr_i[LOW_W-1:0], 2'b00};
               wdat_d  = cmd_dat_i;
               sel_d   = cmd_wstrb_i;
               err_d   = 1'b0;
               retry_d = '0;
            end
         end
         BUS: begin
            // Terminations are resolved ack first, then err, then rty.
            if (wb_ack_i) begin
               state_d = DONE;
               err_d   = 1'b0;
               if (!wr_q) begin
                  rdat_d = wb_dat_i;
               end
            end else if (wb_err_i) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else if (wb_rty_i) begin
               if (retry_q < RETRY_LIMIT) begin
                  state_d = RETRY_WAIT;
                  retry_d = retry_q + 1'b1;
               end else begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end
            end else if (timeout) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
         end
         RETRY_WAIT: begin
            state_d = BUS;
         end
         DONE: begin
            state_d = IDLE;
            if (err_q && (err_cnt_q != 16'hFFFF)) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      wb_cyc_o   = (state_q == BUS);
      wb_stb_o   = (state_q == BUS);
      cmd_ack_o  = (state_q == DONE);
      cmd_err_o  = (state_q == DONE) && err_q;
      cmd_busy_o = (state_q != IDLE);
   end

   assign wb_we_o     = wr_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = wdat_q;
   assign wb_sel_o    = sel_q;
   assign cmd_dat_o   = rdat_q;
   assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_turfio_wb_bank_bridge.sv
// tb/tb_turfio_wb_bank_bridge.sv - randomized self-checking bench for turfio_wb_bank_bridge
module tb_turfio_wb_bank_bridge;

   localparam int MAX_RETRY      = 3;
   localparam int TIMEOUT_CYCLES = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_en_i, cmd_wr_i;
   logic [19:0] cmd_adr_i;
   logic [31:0] cmd_dat_i;
   logic [3:0]  cmd_wstrb_i;
   logic [31:0] cmd_dat_o;
   logic        cmd_ack_o, cmd_err_o, cmd_busy_o;
   logic [3:0]  bank_upper_i;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [24:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i, wb_rty_i;
   logic [15:0] err_count_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: last successful read data and number of error completions.
   logic [31:0] exp_rdat = 32'h0;
   int          exp_errs = 0;

   always #5 clk = ~clk;

   turfio_wb_bank_bridge dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .cmd_en_i     (cmd_en_i),
      .cmd_wr_i     (cmd_wr_i),
      .cmd_adr_i    (cmd_adr_i),
      .cmd_dat_i    (cmd_dat_i),
      .cmd_wstrb_i  (cmd_wstrb_i),
      .cmd_dat_o    (cmd_dat_o),
      .cmd_ack_o    (cmd_ack_o),
      .cmd_err_o    (cmd_err_o),
      .cmd_busy_o   (cmd_busy_o),
      .bank_upper_i (bank_upper_i),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_adr_o     (wb_adr_o),
      .wb_dat_o     (wb_dat_o),
      .wb_sel_o     (wb_sel_o),
      .wb_dat_i     (wb_dat_i),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i),
      .wb_rty_i     (wb_rty_i),
      .err_count_o  (err_count_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Byte address = upper value (zero for bank 0) above the 19-bit word offset, times 4.
   function automatic logic [31:0] model_adr(input logic [19:0] adr, input logic [3:0] up);
      int unsigned bank_n, low, upv;
      bank_n = 32'(adr) / 32'h80000;
      low    = 32'(adr) % 32'h80000;
      upv    = (bank_n == 0) ? 0 : 32'(up);
      return (upv * 32'h200000) + (low * 4);
   endfunction

   function automatic int model_exp_errs(input int e);
      return (e >= 65535) ? 65535 : e + 1;
   endfunction

   // Issue one command and play the slave: nrty rty responses, then err or ack
   // after dly wait cycles per attempt. Called and returns at a negedge.
   task automatic run_txn(input logic wr, input logic [19:0] adr, input logic [31:0] dat,
                          input logic [3:0] strb, input logic [3:0] up, input int nrty,
                          input logic fin_err, input int dly, input logic [31:0] rd);
      logic [31:0] exp_adr;
      logic        exp_err;
      int          attempts;
      logic        done;
      exp_adr  = model_adr(adr, up);
      exp_err  = (nrty > MAX_RETRY) ? 1'b1 : fin_err;
      attempts = 0;
      done     = 1'b0;
      cmd_en_i     = 1'b1;
      cmd_wr_i     = wr;
      cmd_adr_i    = adr;
      cmd_dat_i    = dat;
      cmd_wstrb_i  = strb;
      bank_upper_i = up;
      @(negedge clk);
      cmd_en_i     = 1'b0;
      cmd_adr_i    = 20'($urandom);
      cmd_dat_i    = $urandom;
      cmd_wstrb_i  = 4'($urandom);
      bank_upper_i = 4'($urandom);
      cmd_wr_i     = 1'($urandom);
      while (!done) begin
         for (int k = 0; k < dly; k++) begin
            check_eq("stb_wait", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
            cmd_en_i = 1'($urandom_range(0, 1));
            wb_dat_i = $urandom;
            @(negedge clk);
         end
         attempts++;
         check_eq("stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
         check_eq("busy", {31'd0, cmd_busy_o}, 32'd1);
         check_eq("adr", {7'd0, wb_adr_o}, exp_adr);
         check_eq("we", {31'd0, wb_we_o}, {31'd0, wr});
         if (wr) begin
            check_eq("wdat", wb_dat_o, dat);
            check_eq("sel", {28'd0, wb_sel_o}, {28'd0, strb});
         end
         cmd_en_i = 1'b0;
         if (attempts <= nrty) begin
            wb_rty_i = 1'b1;
         end else if (fin_err) begin
            wb_err_i = 1'b1;
            wb_rty_i = 1'($urandom_range(0, 1));
         end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = rd;
            wb_err_i = 1'($urandom_range(0, 1));
            wb_rty_i = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         wb_rty_i = 1'b0;
         wb_dat_i = $urandom;
         if ((attempts <= nrty) && (attempts <= MAX_RETRY)) begin
            check_eq("retry_gap", {29'd0, wb_cyc_o, wb_stb_o, cmd_ack_o}, 32'd0);
            @(negedge clk);
         end else begin
            check_eq("ack", {31'd0, cmd_ack_o}, 32'd1);
            check_eq("err", {31'd0, cmd_err_o}, {31'd0, exp_err});
            check_eq("cyc_done", {31'd0, wb_cyc_o}, 32'd0);
            done = 1'b1;
         end
      end
      if (exp_err) begin
         exp_errs = model_exp_errs(exp_errs);
      end else if (!wr) begin
         exp_rdat = rd;
      end
      @(negedge clk);
      check_eq("ack_pulse", {31'd0, cmd_ack_o}, 32'd0);
      check_eq("idle", {30'd0, cmd_busy_o, wb_cyc_o}, 32'd0);
      check_eq("err_count", {16'd0, err_count_o}, 32'(exp_errs));
      check_eq("rdat", cmd_dat_o, exp_rdat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic stayed;
      rst = 1'b1;
      cmd_en_i = 1'b0; cmd_wr_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_wstrb_i = '0;
      bank_upper_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_wb", {28'd0, wb_cyc_o, wb_stb_o, wb_we_o, 1'b0}, 32'd0);
      check_eq("rst_cmd", {29'd0, cmd_ack_o, cmd_err_o, cmd_busy_o}, 32'd0);
      check_eq("rst_cnt", {16'd0, err_count_o}, 32'd0);
      check_eq("rst_dat", cmd_dat_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Bank 0 read, ack after 3 wait cycles.
      run_txn(1'b0, 20'h00010, 32'h0, 4'hF, 4'h3, 0, 1'b0, 3, 32'hDEADBEEF);
      // Bank 1 write through upper value 0xA.
      run_txn(1'b1, 20'h80004, 32'h12345678, 4'b0101, 4'hA, 0, 1'b0, 1, 32'h0);
      // Four retries exhaust MAX_RETRY.
      run_txn(1'b0, 20'h00123, 32'h0, 4'hF, 4'h5, 4, 1'b0, 0, 32'h0);
      // Slave error on a write.
      run_txn(1'b1, 20'hFFFFF, 32'hA5A5A5A5, 4'b1000, 4'hF, 0, 1'b1, 2, 32'h0);

      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom), 20'($urandom), $urandom, 4'($urandom), 4'($urandom),
                 int'($urandom_range(0, 4)), 1'($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 3)), $urandom);
      end

      // No slave response.
      cmd_en_i = 1'b1; cmd_wr_i = 1'b0; cmd_adr_i = 20'h80001; bank_upper_i = 4'h2;
      @(negedge clk);
      cmd_en_i = 1'b0;
      stayed = 1'b1;
`ifdef TURFIO_WB_TIMEOUT_EN
      for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
         if (!(wb_cyc_o && wb_stb_o && !cmd_ack_o)) stayed = 1'b0;
         @(negedge clk);
      end
      check_eq("timeout_window", {31'd0, stayed}, 32'd1);
      check_eq("timeout_ack", {30'd0, cmd_ack_o, cmd_err_o}, 32'd3);
      exp_errs = model_exp_errs(exp_errs);
      @(negedge clk);
      check_eq("timeout_cnt", {16'd0, err_count_o}, 32'(exp_errs));
      cmd_en_i = 1'b1;
      @(negedge clk);
      cmd_en_i = 1'b0;
`else
      for (int k = 0; k < TIMEOUT_CYCLES + 45; k++) begin
         if (!(cmd_busy_o && wb_cyc_o && !cmd_ack_o)) stayed = 1'b0;
         @(negedge clk);
      end
      check_eq("no_timeout_busy", {31'd0, stayed}, 32'd1);
      // A new request while busy must not start another cycle.
      cmd_en_i = 1'b1; cmd_adr_i = 20'h00007;
      @(negedge clk);
      cmd_en_i = 1'b0;
      check_eq("ignored_adr", {7'd0, wb_adr_o}, model_adr(20'h80001, 4'h2));
`endif
      @(negedge clk);
      check_eq("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);

      // Reset in the middle of BUS abandons the cycle.
      rst = 1'b1;
      #1;
      check_eq("mid_rst_wb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      check_eq("mid_rst_cmd", {29'd0, cmd_ack_o, cmd_err_o, cmd_busy_o}, 32'd0);
      check_eq("mid_rst_cnt", {16'd0, err_count_o}, 32'd0);
      check_eq("mid_rst_dat", cmd_dat_o, 32'd0);
      exp_errs = 0;
      exp_rdat = 32'h0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst", {29'd0, cmd_ack_o, wb_cyc_o, cmd_busy_o}, 32'd0);

      run_txn(1'b0, 20'h8ABCD, 32'h0, 4'hF, 4'h6, 4, 1'b0, 1, 32'h0);
      run_txn(1'b0, 20'h0ABCD, 32'h0, 4'hF, 4'h6, 2, 1'b0, 0, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
